health_tracker: RTL and testbench

Parametrised multi-hit-point health register for the game datapath. It replaces the single-bit alive/dead flag with a saturating HP counter, damage/heal inputs, and a post-hit invulnerability window. It sends state flags (alive, invulnerable, dead) to the display and game-control FSMs. It sits between the collision detector, which drives `hit`, and the top-level game controller, which drives `start`.

---
 rtl/health_tracker.sv | 74 +++++++
 tb/tb_health_tracker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/health_tracker.sv
// health_tracker: saturating hit-point register with damage/heal netting and a post-hit invulnerability window
module health_tracker #(
  parameter int HP_W = 4,
  parameter int MAX_HP = 8,
  parameter int INVULN_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            hit,
  input  logic [HP_W-1:0] hit_amt,
  input  logic            heal,
  input  logic [HP_W-1:0] heal_amt,
  output logic [HP_W-1:0] health,
  output logic            alive,
  output logic            invuln,
  output logic            dead,
  output logic            hit_ack
);
  localparam int CW = INVULN_CYCLES > 0 ? $clog2(INVULN_CYCLES + 1) : 1;
  localparam int SW = HP_W + 2;
  localparam logic [HP_W-1:0] HP_MAX = HP_W'(MAX_HP);
  localparam logic signed [SW-1:0] SUM_MAX = SW'(MAX_HP);
  localparam logic [CW-1:0] WIN = CW'(INVULN_CYCLES);
  typedef enum logic [1:0] {IDLE, ALIVE, INVULN, DEAD} state_t;
  state_t state_q, state_d;
  logic [HP_W-1:0] health_q, health_d, hit_eff, heal_eff, clamped;
  logic [CW-1:0] cnt_q, cnt_d;
  logic hit_ack_q, hit_ack_d, eff_hit;
  logic signed [SW-1:0] sum;
  always_comb begin
    eff_hit = state_q == ALIVE && hit && hit_amt != '0;
    hit_eff = eff_hit ? hit_amt : '0;
    heal_eff = heal ? heal_amt : '0;
    sum = $signed({2'b00, health_q}) - $signed({2'b00, hit_eff}) + $signed({2'b00, heal_eff});
    clamped = sum[SW-1] ? '0 : sum > SUM_MAX ? HP_MAX : sum[HP_W-1:0];
    state_d = state_q;
    health_d = health_q;
    cnt_d = cnt_q;
    hit_ack_d = 1'b0;
    if (start) begin
      state_d = ALIVE;
      health_d = HP_MAX;
      cnt_d = '0;
    end else if (state_q == ALIVE) begin
      health_d = clamped;
      hit_ack_d = eff_hit;
      state_d = !eff_hit ? ALIVE : clamped == '0 ? DEAD : INVULN_CYCLES > 0 ? INVULN : ALIVE;
      cnt_d = eff_hit && clamped != '0 ? WIN : '0;
    end else if (state_q == INVULN) begin
      health_d = clamped;
      cnt_d = cnt_q - CW'(1);
      state_d = cnt_q == CW'(1) ? ALIVE : INVULN;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      health_q <= '0;
      cnt_q <= '0;
      hit_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      health_q <= health_d;
      cnt_q <= cnt_d;
      hit_ack_q <= hit_ack_d;
    end
  end
  assign health = health_q;
  assign alive = state_q == ALIVE || state_q == INVULN;
  assign invuln = state_q == INVULN;
  assign dead = state_q == DEAD;
  assign hit_ack = hit_ack_q;
endmodule

// File: tb/tb_health_tracker.sv
// tb_health_tracker: directed and randomized checks of health_tracker against a behavioural HP model
module tb_health_tracker;
  localparam int HP_W = 4;
  localparam int MAX = 8;
  localparam int INV = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic hit = 1'b0;
  logic heal = 1'b0;
  logic [HP_W-1:0] hit_amt = '0;
  logic [HP_W-1:0] heal_amt = '0;
  logic [HP_W-1:0] health;
  logic alive, invuln, dead, hit_ack;
  int checks = 0;
  int failures = 0;
  bit m_started = 0;
  bit m_ack = 0;
  int m_hp = 0;
  int m_win = 0;
  health_tracker #(.HP_W(HP_W), .MAX_HP(MAX), .INVULN_CYCLES(INV)) dut (
    .clk(clk), .rst(rst), .start(start), .hit(hit), .hit_amt(hit_amt),
    .heal(heal), .heal_amt(heal_amt), .health(health), .alive(alive),
    .invuln(invuln), .dead(dead), .hit_ack(hit_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    #1;
    chk("model_health", 32'(health), 32'(m_hp));
    chk("model_alive", 32'(alive), 32'(m_started && m_hp > 0));
    chk("model_invuln", 32'(invuln), 32'(m_win > 0));
    chk("model_dead", 32'(dead), 32'(m_started && m_hp == 0));
    chk("model_hit_ack", 32'(hit_ack), 32'(m_ack));
  end
  task automatic model_reset();
    m_started = 0;
    m_hp = 0;
    m_win = 0;
    m_ack = 0;
  endtask
  task automatic step(input bit s, input bit h, input int ha, input bit l, input int la);
    int v;
    bit eff;
    @(negedge clk);
    start = s;
    hit = h;
    hit_amt = HP_W'(ha);
    heal = l;
    heal_amt = HP_W'(la);
    m_ack = 0;
    if (s) begin
      m_started = 1;
      m_hp = MAX;
      m_win = 0;
    end else if (m_started && m_hp > 0) begin
      if (m_win > 0) begin
        m_hp = (m_hp + (l ? la : 0) > MAX) ? MAX : m_hp + (l ? la : 0);
        m_win--;
      end else begin
        eff = h && ha != 0;
        v = m_hp - (eff ? ha : 0) + (l ? la : 0);
        v = v < 0 ? 0 : v > MAX ? MAX : v;
        m_hp = v;
        m_ack = eff;
        if (eff && v > 0) m_win = INV;
      end
    end
  endtask
  task automatic settle();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    start = 0;
    hit = 0;
    heal = 0;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask
  initial begin
    do_reset();
    #1;
    chk("rst_health", 32'(health), 0);
    chk("rst_alive", 32'(alive), 0);
    chk("rst_dead", 32'(dead), 0);
    step(0, 1, 3, 1, 2);
    settle();
    chk("idle_hit_health", 32'(health), 0);
    chk("idle_hit_alive", 32'(alive), 0);
    step(1, 1, 3, 0, 0);
    settle();
    chk("start_health", 32'(health), 8);
    chk("start_alive", 32'(alive), 1);
    chk("start_dead", 32'(dead), 0);
    step(0, 1, 3, 0, 0);
    settle();
    chk("hit3_health", 32'(health), 5);
    chk("hit3_ack", 32'(hit_ack), 1);
    chk("hit3_invuln", 32'(invuln), 1);
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 2, 0, 0);
      settle();
      chk("window_health", 32'(health), 5);
      chk("window_ack", 32'(hit_ack), 0);
      chk("window_invuln", 32'(invuln), 32'(i < 4));
    end
    step(0, 1, 1, 0, 0);
    settle();
    chk("post_window_health", 32'(health), 4);
    chk("post_window_ack", 32'(hit_ack), 1);
    step(0, 0, 0, 1, 2);
    settle();
    chk("heal_in_window_health", 32'(health), 6);
    chk("heal_in_window_invuln", 32'(invuln), 1);
    idle(3);
    step(0, 1, 0, 0, 0);
    settle();
    chk("zero_hit_ack", 32'(hit_ack), 0);
    chk("zero_hit_invuln", 32'(invuln), 0);
    chk("zero_hit_health", 32'(health), 6);
    step(0, 1, 2, 1, 5);
    settle();
    chk("net_health", 32'(health), 8);
    chk("net_invuln", 32'(invuln), 1);
    idle(4);
    step(0, 0, 0, 1, 3);
    settle();
    chk("full_heal_health", 32'(health), 8);
    step(0, 1, 6, 0, 0);
    idle(4);
    settle();
    chk("pre_overkill_health", 32'(health), 2);
    step(0, 1, 7, 0, 0);
    settle();
    chk("overkill_health", 32'(health), 0);
    chk("overkill_dead", 32'(dead), 1);
    chk("overkill_alive", 32'(alive), 0);
    chk("overkill_ack", 32'(hit_ack), 1);
    step(0, 1, 3, 1, 5);
    settle();
    chk("dead_hold_health", 32'(health), 0);
    chk("dead_hold_dead", 32'(dead), 1);
    step(1, 0, 0, 0, 0);
    settle();
    chk("restart_health", 32'(health), 8);
    chk("restart_alive", 32'(alive), 1);
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    #3;
    rst = 1;
    model_reset();
    #1;
    chk("async_rst_health", 32'(health), 0);
    chk("async_rst_invuln", 32'(invuln), 0);
    chk("async_rst_alive", 32'(alive), 0);
    @(negedge clk);
    rst = 0;
    step(1, 0, 0, 0, 0);
    settle();
    chk("post_rst_health", 32'(health), 8);
    chk("post_rst_invuln", 32'(invuln), 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15),
           $urandom_range(0, 3) == 0, $urandom_range(0, 15));
    end
    settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
